trace_capture_monitor: RTL and testbench
========================================

// Module: trace_capture_monitor
// PURPOSE
//   Response-side counterpart of the SBY trace-replay testbench. The replay bench drives
//   miter stimulus cycle by cycle; this block records what the miter does.
//   - Counts cycles from start.
//   - Latches the first cycle on which the miter trigger (assert failure) fires.
//   - Buffers tagged samples of the miter outputs for readout over a valid/ready port.
//   - Deasserts 'running' after MAX_CYCLES, mirroring the bench's genclock.
// PARAMETERS
//   WIDTH       8    width of sampled miter output vector
//   DEPTH       16   capture FIFO entries; power of two, >= 2
//   MAX_CYCLES  2    cycles recorded per run (cycle 0 .. MAX_CYCLES-1); >= 1
//   CW          32   cycle counter / timestamp width
// PORTS
//   clock        in   1        single clock; all state updates on posedge
//   resetn       in   1        asynchronous, active-low reset
//   start        in   1        1-cycle pulse; begins a run (ignored while RUN)
//   sample_valid in   1        sample_in is meaningful this cycle
//   sample_in    in   WIDTH    miter output vector
//   trigger      in   1        miter assertion-failure flag
//   running      out  1        high during RUN (genclock equivalent)
//   done         out  1        high in DONE until next start
//   fail         out  1        sticky: trigger seen during the current run
//   fail_cycle   out  CW       cycle index of first trigger; valid when fail=1
//   overflow     out  1        sticky: a sample was dropped because the FIFO was full
//   rd_valid     out  1        FIFO non-empty
//   rd_ready     in   1        consumer accepts rd_data when rd_valid&rd_ready
//   rd_data      out  CW+WIDTH {timestamp, sample}, FIFO head, first-word-fall-through
// BEHAVIOUR
//   Reset (async, resetn=0): state=IDLE, cycle=0, FIFO empty, all outputs 0.
//   States:
//   - IDLE -> RUN on start.
//   - RUN -> DONE when cycle==MAX_CYCLES-1 at the clock edge.
//   - DONE -> RUN on start.
//   start in IDLE or DONE (same edge):
//   - cycle<=0; fail, fail_cycle and overflow clear.
//   - FIFO is NOT flushed; unread data survives a restart.
//   RUN, every edge:
//   - Sample when sample_valid: push {cycle, sample_in} if not full; else overflow<=1.
//     Samples are taken on the final cycle too.
//   - If trigger && !fail: fail<=1 and fail_cycle<=cycle. Later triggers are ignored.
//   - cycle<=cycle+1, except on the final cycle.
//   - Counter stops at MAX_CYCLES-1 and never wraps.
//   Outside RUN: sample_valid and trigger are ignored.
//   running=(state==RUN); done=(state==DONE); both are registered state decodes.
//   Timing: a sample appears on rd_data the cycle after its capture edge.
//   FIFO:
//   - Pop when rd_valid&&rd_ready.
//   - Simultaneous push+pop when full: the pop frees a slot, so the push succeeds and
//     overflow is not set.
//   - Simultaneous push+pop when empty: the entry is pushed; rd_valid rises next cycle.
//   - Pointers are log2(DEPTH)+1 bits with a wrap bit; full and empty come from the
//     pointer compare.
//   resetn low mid-run: immediate return to reset values; FIFO contents discarded.
// STRUCTURE
//   Package trace_mon_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} mon_state_t.
//   - localparam CW default.
//   - typedef for the {stamp, sample} record.
//   Sub-module trace_fifo (WIDTH, DEPTH):
//   - Async-reset synchronous FIFO with FWFT head.
//   - Ports: push, pop, din, dout, full, empty.
//   Top holds the FSM, cycle counter, fail/overflow latches and FIFO push gating.
// TESTING
//   1 Reset then idle: sample_valid=1 with start low -> rd_valid=0, running=0, no push.
//   2 Default run (MAX_CYCLES=2):
//     - start, samples 0xA5 then 0x3C.
//     - running high 2 cycles, then done=1.
//     - Reads {0,0xA5}, {1,0x3C}.
//   3 Trigger on cycles 1 and 3 (MAX_CYCLES=8) -> fail=1, fail_cycle=1 retained at done.
//   4 Overflow (DEPTH=4, MAX_CYCLES=8, rd_ready=0, sample every cycle):
//     - 4 entries with stamps 0..3; overflow=1.
//     - Repeat with rd_ready=1 throughout -> 8 reads, overflow=0.
//   5 resetn low at cycle 3 of an 8-cycle run -> all outputs 0 immediately.
//     Next start records stamps from 0.
//   6 Restart from DONE with 2 unread entries -> old entries read first.
//     fail and overflow clear at start; new stamps restart at 0.

Source files
------------

// File: rtl/trace_mon_pkg.sv
//------------------------------------------------------------------------------
// trace_mon_pkg : shared types for the trace capture monitor
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package trace_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mon_state_t;

  localparam int TRACE_CW    = 32;
  localparam int TRACE_WIDTH = 8;

  // Readout record at default widths: timestamp in the upper bits.
  typedef struct packed {
    logic [TRACE_CW-1:0]    stamp;
    logic [TRACE_WIDTH-1:0] sample;
  } trace_rec_t;

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
//------------------------------------------------------------------------------
// trace_fifo : synchronous FIFO with first-word-fall-through head
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on the same edge frees the slot a push into a full FIFO needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Head reads as zero when empty so stale storage never reaches the port.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/trace_capture_monitor.sv
//------------------------------------------------------------------------------
// trace_capture_monitor : records cycle count, first trigger and tagged samples
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_capture_monitor
  import trace_mon_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 2,
  parameter int CW         = TRACE_CW
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                sample_valid,
  input  logic [WIDTH-1:0]    sample_in,
  input  logic                trigger,
  output logic                running,
  output logic                done,
  output logic                fail,
  output logic [CW-1:0]       fail_cycle,
  output logic                overflow,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [CW+WIDTH-1:0] rd_data
);

  localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);

  mon_state_t    state;
  mon_state_t    state_next;
  logic [CW-1:0] cycle;
  logic          last_cycle;
  logic          start_run;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign last_cycle = (cycle == LAST_CYCLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    running    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          start_run  = 1'b1;
        end
      end
      RUN: begin
        running = 1'b1;
        if (last_cycle) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = RUN;
          start_run  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign push     = running && sample_valid;
  assign pop      = rd_valid && rd_ready;
  assign rd_valid = !empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cycle      <= '0;
      fail       <= 1'b0;
      fail_cycle <= '0;
      overflow   <= 1'b0;
    end else if (start_run) begin
      cycle      <= '0;
      fail       <= 1'b0;
      fail_cycle <= '0;
      overflow   <= 1'b0;
    end else if (running) begin
      if (push && full && !pop) overflow <= 1'b1;
      if (trigger && !fail) begin
        fail       <= 1'b1;
        fail_cycle <= cycle;
      end
      // Counter parks on the final cycle rather than wrapping.
      if (!last_cycle) cycle <= cycle + CW'(1);
    end
  end

  trace_fifo #(
    .WIDTH(CW + WIDTH),
    .DEPTH(DEPTH)
  ) fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (push),
    .pop   (pop),
    .din   ({cycle, sample_in}),
    .dout  (rd_data),
    .full  (full),
    .empty (empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_trace_capture_monitor.sv
//------------------------------------------------------------------------------
// tb_trace_capture_monitor : two monitor configurations against a queue model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_trace_capture_monitor;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic sample_valid = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic trigger = 1'b0;
  logic rd_ready = 1'b0;

  logic running_a, done_a, fail_a, overflow_a, rd_valid_a;
  logic [31:0] fail_cycle_a;
  logic [39:0] rd_data_a;
  logic running_b, done_b, fail_b, overflow_b, rd_valid_b;
  logic [31:0] fail_cycle_b;
  logic [39:0] rd_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Instance a: default configuration. Instance b: shallow FIFO, long run.
  trace_capture_monitor #(.WIDTH(8), .DEPTH(16), .MAX_CYCLES(2), .CW(32)) dut_a (
    .clock(clock), .resetn(resetn), .start(start), .sample_valid(sample_valid),
    .sample_in(sample_in), .trigger(trigger), .running(running_a), .done(done_a),
    .fail(fail_a), .fail_cycle(fail_cycle_a), .overflow(overflow_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a));

  trace_capture_monitor #(.WIDTH(8), .DEPTH(4), .MAX_CYCLES(8), .CW(32)) dut_b (
    .clock(clock), .resetn(resetn), .start(start), .sample_valid(sample_valid),
    .sample_in(sample_in), .trigger(trigger), .running(running_b), .done(done_b),
    .fail(fail_b), .fail_cycle(fail_cycle_b), .overflow(overflow_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b));

  function automatic int dep(int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int maxc(int k);
    return (k == 0) ? 2 : 8;
  endfunction

  // Model: phase 0 idle, 1 run, 2 done; FIFO as a circular array.
  int          m_phase [2];
  int          m_cycle [2];
  bit          m_fail  [2];
  int          m_fc    [2];
  bit          m_ovf   [2];
  logic [39:0] m_mem   [2][16];
  int          m_head  [2];
  int          m_cnt   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_cycle[k] = 0; m_fail[k] = 0; m_fc[k] = 0;
      m_ovf[k] = 0; m_head[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    bit pop;
    bit push_ok;
    logic [39:0] rec;
    pop = (m_cnt[k] > 0) && rd_ready;
    push_ok = 0;
    rec = {m_cycle[k][31:0], sample_in};
    if (m_phase[k] == 1) begin
      if (sample_valid) begin
        if (m_cnt[k] < dep(k) || pop) push_ok = 1;
        else m_ovf[k] = 1;
      end
      if (trigger && !m_fail[k]) begin
        m_fail[k] = 1;
        m_fc[k] = m_cycle[k];
      end
      if (m_cycle[k] == maxc(k) - 1) m_phase[k] = 2;
      else m_cycle[k] = m_cycle[k] + 1;
    end else if (start) begin
      m_phase[k] = 1; m_cycle[k] = 0; m_fail[k] = 0; m_fc[k] = 0; m_ovf[k] = 0;
    end
    if (pop) begin
      m_head[k] = (m_head[k] + 1) % dep(k);
      m_cnt[k] = m_cnt[k] - 1;
    end
    if (push_ok) begin
      m_mem[k][(m_head[k] + m_cnt[k]) % dep(k)] = rec;
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  always @(posedge clock or negedge resetn) begin
    if (!resetn) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  function automatic logic [39:0] exp_data(int k);
    return (m_cnt[k] > 0) ? m_mem[k][m_head[k]] : 40'h0;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("a_running",    64'(running_a),    64'(m_phase[0] == 1));
    chk("a_done",       64'(done_a),       64'(m_phase[0] == 2));
    chk("a_fail",       64'(fail_a),       64'(m_fail[0]));
    chk("a_fail_cycle", 64'(fail_cycle_a), 64'(m_fc[0]));
    chk("a_overflow",   64'(overflow_a),   64'(m_ovf[0]));
    chk("a_rd_valid",   64'(rd_valid_a),   64'(m_cnt[0] > 0));
    chk("a_rd_data",    64'(rd_data_a),    64'(exp_data(0)));
    chk("b_running",    64'(running_b),    64'(m_phase[1] == 1));
    chk("b_done",       64'(done_b),       64'(m_phase[1] == 2));
    chk("b_fail",       64'(fail_b),       64'(m_fail[1]));
    chk("b_fail_cycle", 64'(fail_cycle_b), 64'(m_fc[1]));
    chk("b_overflow",   64'(overflow_b),   64'(m_ovf[1]));
    chk("b_rd_valid",   64'(rd_valid_b),   64'(m_cnt[1] > 0));
    chk("b_rd_data",    64'(rd_data_b),    64'(exp_data(1)));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    trace_mon_pkg::trace_rec_t rec;

    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // Idle: samples are ignored without a start
    sample_valid = 1'b1; sample_in = 8'h77;
    repeat (3) cyc();
    @(negedge clock);
    chk("lit_idle_rd_valid", 64'(rd_valid_a), 64'd0);
    chk("lit_idle_running",  64'(running_a),  64'd0);
    chk("lit_idle_rd_valid_b", 64'(rd_valid_b), 64'd0);

    // Default two-cycle run
    sample_valid = 1'b0;
    pulse_start();
    sample_valid = 1'b1; sample_in = 8'hA5;
    @(negedge clock);
    chk("lit_run_running0", 64'(running_a), 64'd1);
    cyc();
    sample_in = 8'h3C;
    @(negedge clock);
    chk("lit_run_running1", 64'(running_a), 64'd1);
    cyc();
    sample_valid = 1'b0;
    @(negedge clock);
    chk("lit_run_done", 64'(done_a), 64'd1);
    chk("lit_run_read0", 64'(rd_data_a), 64'({32'd0, 8'hA5}));
    rd_ready = 1'b1;
    cyc();
    @(negedge clock);
    chk("lit_run_read1", 64'(rd_data_a), 64'({32'd1, 8'h3C}));
    repeat (12) cyc();

    // First trigger latched, later ones ignored
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      trigger = (i == 1 || i == 3);
      cyc();
    end
    trigger = 1'b0;
    @(negedge clock);
    chk("lit_trig_done_b",  64'(done_b),       64'd1);
    chk("lit_trig_fail_b",  64'(fail_b),       64'd1);
    chk("lit_trig_cycle_b", 64'(fail_cycle_b), 64'd1);
    chk("lit_trig_cycle_a", 64'(fail_cycle_a), 64'd1);

    // Overflow with the consumer stalled, then none with it always ready
    rd_ready = 1'b0;
    pulse_start();
    sample_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_in = 8'($urandom);
      cyc();
    end
    sample_valid = 1'b0;
    @(negedge clock);
    chk("lit_ovf_set_b", 64'(overflow_b), 64'd1);
    rec = rd_data_b;
    chk("lit_ovf_head_stamp", 64'(rec.stamp), 64'd0);
    chk("lit_ovf_a_clear", 64'(overflow_a), 64'd0);
    rd_ready = 1'b1;
    repeat (10) cyc();
    pulse_start();
    sample_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_in = 8'($urandom);
      cyc();
    end
    sample_valid = 1'b0;
    @(negedge clock);
    chk("lit_ovf_clear_b", 64'(overflow_b), 64'd0);
    repeat (6) cyc();

    // Asynchronous reset mid-run
    pulse_start();
    sample_valid = 1'b1; sample_in = 8'h99;
    repeat (3) cyc();
    resetn = 1'b0;
    #1;
    chk("lit_rst_running", 64'(running_b),  64'd0);
    chk("lit_rst_rd_valid", 64'(rd_valid_b), 64'd0);
    chk("lit_rst_rd_data", 64'(rd_data_b),  64'd0);
    sample_valid = 1'b0;
    cyc();
    resetn = 1'b1;
    pulse_start();
    sample_valid = 1'b1; sample_in = 8'h5A;
    cyc();
    sample_valid = 1'b0;
    @(negedge clock);
    chk("lit_rst_restamp", 64'(rd_data_b), 64'({32'd0, 8'h5A}));
    rd_ready = 1'b1;
    repeat (10) cyc();

    // Restart from done keeps unread entries and clears fail
    rd_ready = 1'b0;
    pulse_start();
    sample_valid = 1'b1; trigger = 1'b1; sample_in = 8'h11;
    cyc();
    sample_in = 8'h22;
    cyc();
    sample_valid = 1'b0; trigger = 1'b0;
    @(negedge clock);
    chk("lit_rs_fail_before", 64'(fail_a), 64'd1);
    pulse_start();
    @(negedge clock);
    chk("lit_rs_fail_clear", 64'(fail_a), 64'd0);
    chk("lit_rs_old_head", 64'(rd_data_a), 64'({32'd0, 8'h11}));
    sample_valid = 1'b1; sample_in = 8'h33;
    cyc();
    sample_valid = 1'b0;
    rd_ready = 1'b1;
    cyc();
    @(negedge clock);
    chk("lit_rs_old_second", 64'(rd_data_a), 64'({32'd1, 8'h22}));
    cyc();
    @(negedge clock);
    chk("lit_rs_new_first", 64'(rd_data_a), 64'({32'd0, 8'h33}));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      start        = ($urandom_range(0, 7) == 0);
      sample_valid = $urandom_range(0, 1) == 1;
      sample_in    = 8'($urandom);
      trigger      = ($urandom_range(0, 5) == 0);
      rd_ready     = ($urandom_range(0, 2) != 0);
      cyc();
    end
    start = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
    repeat (3) cyc();
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
